// File: rtl/print_uart_pkg.sv
// Shared types and bus layout for the print_out UART bridge.
package print_uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int unsigned PRINT_STROBE_BIT = 48;
  localparam int unsigned PRINT_W          = 49;
  localparam int unsigned CHAR_W           = 8;

endpackage

// File: rtl/print_fifo.sv
// Synchronous first-word-fall-through FIFO; level is one bit wider than the pointers.
module print_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_wr, do_rd;

  assign do_wr   = wr_en && (level_q != FULL_LEVEL);
  assign do_rd   = rd_en && (level_q != '0);
  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_wr && !do_rd) begin
        level_q <= level_q + 1'b1;
      end else if (do_rd && !do_wr) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/picorv_print_uart.sv
// Captures print_out character strobes into a FIFO and sends them as 8N1 UART.
module picorv_print_uart
  import print_uart_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [PRINT_W-1:0]     print_in,
  output logic                   uart_txd,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   busy,
  output logic                   overflow,
  output logic [15:0]            drop_count
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(CLKS_PER_BIT - 1);

  logic              strobe, accept, drop, fifo_empty, pop;
  logic [CHAR_W-1:0] char_in, fifo_rd_data;
  logic              unused_print_bits;

  tx_state_t         state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [CHAR_W-1:0] shift_q, shift_d;
  logic              txd_q, txd_d;
  logic              overflow_q;
  logic [15:0]       drop_count_q;

  assign strobe            = print_in[PRINT_STROBE_BIT];
  assign char_in           = print_in[CHAR_W-1:0];
  assign unused_print_bits = ^print_in[PRINT_STROBE_BIT-1:CHAR_W];

  // Full check uses the registered level, so a same-edge pop never rescues a write.
  assign accept     = strobe && (fifo_level != FULL_LEVEL);
  assign drop       = strobe && (fifo_level == FULL_LEVEL);
  assign fifo_empty = (fifo_level == '0);

  print_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CHAR_W)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (accept),
    .wr_data (char_in),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .level   (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = fifo_rd_data;
          bit_cnt_d = '0;
          timer_d   = TIMER_LOAD;
          state_d   = START;
        end
      end
      START: begin
        if (timer_q == '0) begin
          timer_d = TIMER_LOAD;
          state_d = DATA;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      DATA: begin
        if (timer_q == '0) begin
          timer_d   = TIMER_LOAD;
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      STOP: begin
        if (timer_q == '0) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_d   = fifo_rd_data;
            bit_cnt_d = '0;
            timer_d   = TIMER_LOAD;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the state being entered so the output is glitch-free.
    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
    end
  end

  assign uart_txd   = txd_q;
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_picorv_print_uart.sv
// Bench for picorv_print_uart: frame-position reference model, frame table and directed corners.
module tb_picorv_print_uart;

  localparam int DEPTH = 4;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk;
  logic        resetn;
  logic [48:0] print_in;
  logic        uart_txd;
  logic [2:0]  fifo_level;
  logic        busy;
  logic        overflow;
  logic [15:0] drop_count;

  picorv_print_uart #(
    .DEPTH        (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .print_in   (print_in),
    .uart_txd   (uart_txd),
    .fifo_level (fifo_level),
    .busy       (busy),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of chars plus the position inside the current frame.
  int         mq[$];
  bit         m_active;
  int         m_el;
  logic [7:0] m_cur;
  bit         m_ovf;
  int         m_drops;

  task automatic model_update();
    int  pre;
    bit  pop;
    if (!resetn) begin
      mq.delete();
      m_active = 0;
      m_el     = 0;
      m_ovf    = 0;
      m_drops  = 0;
      return;
    end
    pre = mq.size();
    pop = (pre > 0) && (!m_active || m_el == FRAME - 1);
    if (m_active) begin
      if (m_el == FRAME - 1) begin
        if (pop) m_el = 0;
        else m_active = 0;
      end else begin
        m_el++;
      end
    end else if (pop) begin
      m_active = 1;
      m_el     = 0;
    end
    if (pop) m_cur = 8'(mq.pop_front());
    if (print_in[48]) begin
      if (pre < DEPTH) begin
        mq.push_back(int'(print_in[7:0]));
      end else begin
        m_ovf = 1;
        if (m_drops < 65535) m_drops++;
      end
    end
  endtask

  task automatic compare_model();
    int   idx;
    logic exp_txd;
    exp_txd = 1'b1;
    if (m_active) begin
      idx = m_el / CPB;
      if (idx == 0) exp_txd = 1'b0;
      else if (idx <= 8) exp_txd = m_cur[idx-1];
    end
    chk("m_txd", uart_txd, exp_txd);
    chk("m_level", fifo_level, mq.size());
    chk("m_busy", busy, (m_active || mq.size() != 0) ? 1 : 0);
    chk("m_overflow", overflow, m_ovf);
    chk("m_drop_count", drop_count, m_drops);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    compare_model();
  endtask

  task automatic drive(bit s, logic [7:0] c, logic [39:0] hi);
    print_in = {s, hi, c};
  endtask

  task automatic wait_idle(int bound);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < bound) begin
      tick();
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  // Passive UART receiver, sampling mid-bit; frames cut by reset are discarded.
  logic [7:0] rx_q[$];
  int         rx_bad = 0;

  initial begin : rx_mon
    forever begin
      @(posedge clk);
      #2;
      if (resetn === 1'b1 && uart_txd === 1'b0) begin : frame
        logic [7:0] b;
        bit         ok;
        ok = 1;
        repeat (CPB / 2) begin
          @(posedge clk); #2;
          if (resetn !== 1'b1) ok = 0;
        end
        if (uart_txd !== 1'b0) ok = 0;
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) begin
            @(posedge clk); #2;
            if (resetn !== 1'b1) ok = 0;
          end
          b[k] = uart_txd;
        end
        repeat (CPB) begin
          @(posedge clk); #2;
          if (resetn !== 1'b1) ok = 0;
        end
        if (uart_txd !== 1'b1) ok = 0;
        if (ok) rx_q.push_back(b);
        else rx_bad++;
      end
    end
  end

  typedef struct {
    logic [7:0]  ch;
    logic [39:0] hi;
    logic [9:0]  frame;  // bit i is the line level during UART bit slot i
  } vec_t;

  vec_t vecs[6];
  logic s[80];

  initial begin
    logic [7:0] b1, b2;
    int         peak;
    int         mode;

    vecs[0] = '{ch: 8'h41, hi: 40'h0,            frame: 10'b1010000010};
    vecs[1] = '{ch: 8'h55, hi: 40'h0,            frame: 10'b1010101010};
    vecs[2] = '{ch: 8'hAA, hi: 40'h0,            frame: 10'b1101010100};
    vecs[3] = '{ch: 8'h0A, hi: 40'hFF_FFFF_FFFF, frame: 10'b1000010100};
    vecs[4] = '{ch: 8'h00, hi: 40'h12_3456_789A, frame: 10'b1000000000};
    vecs[5] = '{ch: 8'hFF, hi: 40'h0,            frame: 10'b1111111110};

    resetn   = 1'b0;
    print_in = '0;
    repeat (3) tick();
    chk("rst_txd", uart_txd, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_count", drop_count, 0);
    resetn = 1'b1;
    tick();

    // Frame table: exact per-cycle line levels and strobe-to-start latency.
    for (int i = 0; i < 6; i++) begin
      rx_q.delete();
      drive(1, vecs[i].ch, vecs[i].hi);
      tick();
      chk("tbl_level", fifo_level, 1);
      chk("tbl_pre_start", uart_txd, 1);
      drive(0, 8'h00, 40'h0);
      tick();
      for (int j = 0; j < FRAME; j++) begin
        if (j > 0) tick();
        chk("tbl_frame_bit", uart_txd, vecs[i].frame[j / CPB]);
      end
      chk("tbl_busy_stop", busy, 1);
      tick();
      chk("tbl_busy_end", busy, 0);
      chk("tbl_rx_count", rx_q.size(), 1);
      if (rx_q.size() > 0) chk("tbl_rx_char", rx_q[0], vecs[i].ch);
    end

    // Back-to-back pair with no idle gap between frames.
    rx_q.delete();
    drive(1, 8'h55, 40'h0);
    tick();
    drive(1, 8'hAA, 40'h0);
    tick();
    drive(0, 8'h00, 40'h0);
    s[0] = uart_txd;
    for (int i = 1; i < 80; i++) begin
      tick();
      s[i] = uart_txd;
    end
    for (int k = 0; k < 8; k++) begin
      b1[k] = s[(k + 1) * CPB + CPB / 2];
      b2[k] = s[FRAME + (k + 1) * CPB + CPB / 2];
    end
    chk("b2b_start1", s[0], 0);
    chk("b2b_stop1_end", s[FRAME-1], 1);
    chk("b2b_start2_nogap", s[FRAME], 0);
    chk("b2b_stop2", s[79], 1);
    chk("b2b_byte1", b1, 8'h55);
    chk("b2b_byte2", b2, 8'hAA);
    wait_idle(20);

    // Overflow: six consecutive strobes into a four-deep FIFO.
    rx_q.delete();
    peak = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 8'(8'h30 + i), 40'h0);
      tick();
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
    drive(0, 8'h00, 40'h0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop_count", drop_count, 1);
    chk("ovf_peak_level", peak, 4);
    wait_idle(300);
    chk("ovf_rx_count", rx_q.size(), 5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++) chk("ovf_rx_char", rx_q[i], 8'h30 + i);

    // Saturation: strobe continuously so the FIFO stays full.
    for (int i = 0; i < 70000; i++) begin
      drive(1, 8'($urandom), 40'h0);
      tick();
    end
    drive(0, 8'h00, 40'h0);
    chk("sat_drop_count", drop_count, 16'hFFFF);
    chk("sat_overflow", overflow, 1);
    wait_idle(400);

    // Reset during DATA bit 3 with three chars still queued.
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'(8'h61 + i), 40'h0);
      tick();
    end
    drive(0, 8'h00, 40'h0);
    repeat (15) tick();
    chk("rstm_level_before", fifo_level, 3);
    resetn = 1'b0;
    tick();
    chk("rstm_txd", uart_txd, 1);
    chk("rstm_level", fifo_level, 0);
    chk("rstm_busy", busy, 0);
    chk("rstm_drop_count", drop_count, 0);
    tick();
    resetn = 1'b1;
    repeat (50) tick();
    rx_q.delete();
    drive(1, 8'h41, 40'h0);
    tick();
    drive(0, 8'h00, 40'h0);
    wait_idle(60);
    chk("rstm_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("rstm_rx_char", rx_q[0], 8'h41);

    // Ignored bits: no strobe with data present, then strobe with upper bits set.
    rx_q.delete();
    drive(0, 8'hFF, 40'h0);
    tick();
    chk("ign_no_strobe_level", fifo_level, 0);
    drive(1, 8'h0A, 40'hFF_FFFF_FFFF);
    tick();
    drive(0, 8'hFF, 40'hFF_FFFF_FFFF);
    wait_idle(60);
    chk("ign_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("ign_rx_char", rx_q[0], 8'h0A);

    // Randomized traffic with occasional resets, checked every cycle by the model.
    mode = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) mode = int'($urandom_range(0, 2));
      resetn = ($urandom_range(0, 599) != 0);
      case (mode)
        0:       drive($urandom_range(0, 29) == 0, 8'($urandom), {8'($urandom), 32'($urandom)});
        1:       drive($urandom_range(0, 1) == 0, 8'($urandom), {8'($urandom), 32'($urandom)});
        default: drive($urandom_range(0, 7) == 0, 8'($urandom), {8'($urandom), 32'($urandom)});
      endcase
      tick();
    end
    resetn = 1'b1;
    drive(0, 8'h00, 40'h0);
    wait_idle(400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/picorv_print_uart.md
# picorv_print_uart

Downstream consumer of the core wrapper's 49-bit `print_out` debug bus. It captures each character strobe into a small synchronous FIFO and serialises it as 8N1 UART on a single pin, so firmware `putchar` writes to 0x1000_0000 reach a host terminal. The producer has no backpressure, so characters arriving while the FIFO is full are dropped and counted.

## Interface
- `DEPTH`, default 16: FIFO entries; power of two, ≥ 2.
- `CLKS_PER_BIT`, default 868: clk cycles per UART bit (100 MHz / 115200); ≥ 2.
- `clk`  in  1  clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `print_in`  in  49  producer bus:
  - bit 48 is the one-cycle char strobe.
  - bits 7:0 are the character.
  - bits 47:8 are ignored.
- `uart_txd`  out  1  serial line; idle high.
- `fifo_level`  out  $clog2(DEPTH)+1  entries currently queued.
- `busy`  out  1  high when the FSM is not IDLE or `fifo_level` ≠ 0.
- `overflow`  out  1  sticky; set on the first dropped char.
- `drop_count`  out  16  dropped chars; saturates at 0xFFFF.

## Operation
- **Capture:** on each edge where `print_in[48]`=1:
  - if the registered `fifo_level` < DEPTH, write `print_in[7:0]`;
  - otherwise drop the char, set `overflow`, and increment `drop_count` (saturating).
- The full check uses the pre-edge level. A write on full is dropped even if a pop happens on the same edge.
- **Simultaneous write and pop:** both occur and the level is unchanged.
- **TX FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** if the FIFO is non-empty, pop into an 8-bit shift register, clear `bit_cnt`, load the timer with CLKS_PER_BIT-1, go to START.
  - **START:** `uart_txd`=0. When the timer reaches 0, reload it and go to DATA.
  - **DATA:** `uart_txd`=shift[0], LSB first. On timer 0, shift right and increment `bit_cnt`. After bit 7, go to STOP.
  - **STOP:** `uart_txd`=1. On timer 0:
    - if the FIFO is non-empty, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- `uart_txd` is a registered output, driven from the next state.
- Timer width is $clog2(CLKS_PER_BIT); `bit_cnt` is 3 bits.
- FIFO pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. The level counter is one bit wider so it can represent full.
- **Reset mid-frame:** the frame is abandoned and `uart_txd` is high after the next edge. The FIFO is emptied and the counters are cleared.

## Timing
- Reset values:
  - `uart_txd`=1, `fifo_level`=0, `busy`=0, `overflow`=0, `drop_count`=0.
  - FSM in IDLE, pointers and timer at 0.
- A strobe sampled at edge N gives `fifo_level`+1 after edge N.
- With the FSM in IDLE, a pop occurs at edge N+1 and `uart_txd` falls after edge N+1. Latency from strobe to start bit is 2 edges.
- Each bit lasts exactly CLKS_PER_BIT cycles; a frame lasts 10·CLKS_PER_BIT cycles.
- Back-to-back frames have zero idle cycles between the stop bit and the next start bit.
- `busy` is combinational from registered state and level.
- Throughput limit: one char per 10·CLKS_PER_BIT cycles. Bursts larger than DEPTH+1 overflow.

## Structure
- Package `print_uart_pkg` contains:
  - enum `tx_state_t` {IDLE, START, DATA, STOP};
  - localparams `PRINT_STROBE_BIT`=48 and `PRINT_W`=49;
  - the char width of 8.
- Sub-module `print_fifo`: a synchronous FIFO with parameters DEPTH and WIDTH=8. Ports: wr_en, wr_data, rd_en, rd_data (first-word fall-through), level.
- The top level holds the capture/drop logic, the counters and the TX FSM.

## Test plan
- **Single char**, CLKS_PER_BIT=4: strobe 0x41.
  - `uart_txd` is low 4 cycles, then bits 1,0,0,0,0,0,1,0 for 4 cycles each, then high 4 cycles.
  - Start bit falls 2 edges after the strobe; `busy` drops after the stop bit.
- **Back-to-back**: strobe 0x55 then 0xAA on consecutive cycles.
  - Two frames of 40 cycles each with no high gap between the first stop bit and the second start bit.
  - Decoded bytes are 0x55, 0xAA.
- **Overflow**, DEPTH=4: 6 strobes on consecutive cycles with chars 0x30–0x35.
  - 0x30–0x34 are transmitted and 0x35 is dropped.
  - `overflow`=1, `drop_count`=1, peak `fifo_level`=4.
- **Saturation**: hold the FIFO full and issue 70000 strobes.
  - `drop_count` stays at 0xFFFF.
- **Reset mid-frame**: assert `resetn`=0 during DATA bit 3 with 3 chars queued.
  - After the next edge: `uart_txd`=1, `fifo_level`=0, `busy`=0.
  - After release, a new 0x41 transmits cleanly.
- **Ignored bits**: strobe=0 with `print_in[7:0]`=0xFF, then strobe=1 with bits 47:8 all ones and char 0x0A.
  - Only 0x0A is queued and transmitted.
